// File: rtl/avmm_pkg.sv
// Shared types and constants for the avmm_word_mem pipelined Avalon-MM memory slave.
package avmm_pkg;

   localparam int WORD_W = 32;

   typedef logic [WORD_W-1:0] word_t;

   localparam word_t       OOB_PATTERN = 32'hDEAD_BEEF;
   localparam logic [15:0] LFSR_SEED   = 16'hACE1;

   typedef struct packed {
      logic  valid;
      word_t data;
   } rd_stage_t;

   // Fibonacci step for x^16 + x^14 + x^13 + x^11 + 1
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

endpackage

// File: rtl/avmm_word_mem_if.sv
// Avalon-MM slave bus bundle between the wordcopy master and avmm_word_mem.
interface avmm_word_mem_if;
   import avmm_pkg::*;

   logic [31:0] slave_address;
   logic        slave_read;
   logic        slave_write;
   word_t       slave_writedata;
   logic        slave_waitrequest;
   word_t       slave_readdata;
   logic        slave_readdatavalid;
   logic        err_oob;

   modport master (
      output slave_address, slave_read, slave_write, slave_writedata,
      input  slave_waitrequest, slave_readdata, slave_readdatavalid, err_oob
   );

   modport slave (
      input  slave_address, slave_read, slave_write, slave_writedata,
      output slave_waitrequest, slave_readdata, slave_readdatavalid, err_oob
   );

endinterface

// File: rtl/avmm_lat_pipe.sv
// Fixed-latency read-return shift register; the last stage is the bus response.
module avmm_lat_pipe
   import avmm_pkg::*;
#(
   parameter int LAT = 2
) (
   input  logic      clk,
   input  logic      rst,
   input  rd_stage_t in_stage,
   output rd_stage_t out_stage
);

   rd_stage_t stg [LAT];

   // Data only moves with a valid token so the output holds the last returned word.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < LAT; i++) stg[i] <= '0;
      end else begin
         stg[0].valid <= in_stage.valid;
         if (in_stage.valid) stg[0].data <= in_stage.data;
         for (int i = 1; i < LAT; i++) begin
            stg[i].valid <= stg[i-1].valid;
            if (stg[i-1].valid) stg[i].data <= stg[i-1].data;
         end
      end
   end

   assign out_stage = stg[LAT-1];

endmodule

// File: rtl/avmm_word_mem.sv
// Pipelined Avalon-MM word memory with in-order fixed-latency reads and pending-read throttling.
// Optional random waitrequest stalls when AVMM_STALL_INJECT_EN is defined.
module avmm_word_mem
   import avmm_pkg::*;
#(
   parameter int    ADDR_W    = 10,
   parameter int    READ_LAT  = 2,
   parameter int    MAX_PEND  = 2,
   parameter string INIT_FILE = ""
) (
   input logic           clk,
   input logic           rst,
   avmm_word_mem_if.slave bus
);

   localparam int DEPTH  = 2 ** ADDR_W;
   localparam int PEND_W = $clog2(MAX_PEND + 1);

   word_t             mem [DEPTH];
   logic [PEND_W-1:0] pend;
   logic [ADDR_W-1:0] idx;
   logic              oob;
   logic              stall;
   logic              accept;
   logic              wr_acc;
   logic              rd_acc;
   logic              err_q;
   rd_stage_t         rd_in;
   rd_stage_t         rd_out;

   initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;

`ifdef AVMM_STALL_INJECT_EN
   logic [15:0] lfsr;

   always_ff @(posedge clk) begin
      if (rst) lfsr <= LFSR_SEED;
      else     lfsr <= lfsr_next(lfsr);
   end

   assign stall = (lfsr[1:0] == 2'b00);
`else
   assign stall = 1'b0;
`endif

   assign idx = bus.slave_address[ADDR_W+1:2];
   assign oob = (|bus.slave_address[31:ADDR_W+2]) | (|bus.slave_address[1:0]);

   // A returning read frees a slot in the same cycle, so a full pipe still streams.
   assign bus.slave_waitrequest = rst | stall
                                | ((pend == PEND_W'(MAX_PEND)) & ~rd_out.valid);

   assign accept = (bus.slave_read | bus.slave_write) & ~bus.slave_waitrequest;
   assign wr_acc = accept & bus.slave_write & ~oob;
   assign rd_acc = accept & bus.slave_read & ~bus.slave_write;

   always_ff @(posedge clk) begin
      if (wr_acc) mem[idx] <= bus.slave_writedata;
   end

   always_comb begin
      rd_in       = '0;
      rd_in.valid = rd_acc;
      rd_in.data  = oob ? OOB_PATTERN : mem[idx];
   end

   avmm_lat_pipe #(.LAT(READ_LAT)) u_lat_pipe (
      .clk       (clk),
      .rst       (rst),
      .in_stage  (rd_in),
      .out_stage (rd_out)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         pend <= '0;
      end else if (rd_acc & ~rd_out.valid) begin
         pend <= pend + PEND_W'(1);
      end else if (~rd_acc & rd_out.valid) begin
         pend <= pend - PEND_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst)                err_q <= 1'b0;
      else if (accept & oob)  err_q <= 1'b1;
   end

   assign bus.slave_readdatavalid = rd_out.valid;
   assign bus.slave_readdata      = rd_out.data;
   assign bus.err_oob             = err_q;

endmodule
